// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: burst-locked round-robin arbiter sharing one memory port between a writer and a reader
module mem_port_arbiter #(
    parameter int SLV_AW    = 10,
    parameter int SLV_BYTES = 16,
    parameter int SLV_WS    = 0
) (
    input  logic                   usr_clk,
    input  logic                   usr_reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [SLV_AW-1:0]      wr_addr,
    input  logic [SLV_BYTES-1:0]   wr_be,
    input  logic [8*SLV_BYTES-1:0] wr_data,
    input  logic                   wr_last,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [SLV_AW-1:0]      rd_addr,
    input  logic                   rd_last,
    output logic                   rd_dvalid,
    output logic [8*SLV_BYTES-1:0] rd_data,
    output logic                   mem_we,
    output logic [SLV_AW-1:0]      mem_addr,
    output logic [SLV_BYTES-1:0]   mem_be,
    output logic [8*SLV_BYTES-1:0] mem_wdata,
    input  logic [8*SLV_BYTES-1:0] mem_q,
    output logic                   busy
);
    localparam int TW = (SLV_WS > 0) ? SLV_WS : 1;
    typedef enum logic [1:0] {IDLE, WLOCK, RLOCK} state_t;
    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic [TW-1:0]     trk_q, trk_d;
    logic [SLV_AW-1:0] addr_q, addr_d;
    logic              wr_acc, rd_acc;
    // grant decode, memory port steering and next-state; a lock owns the port until its last beat
    always_comb begin
        wr_ready  = (state_q == WLOCK) || (state_q == IDLE && wr_valid && (!rd_valid || !prio_q));
        rd_ready  = (state_q == RLOCK) || (state_q == IDLE && rd_valid && (!wr_valid || prio_q));
        wr_acc    = wr_valid && wr_ready;
        rd_acc    = rd_valid && rd_ready;
        state_d   = wr_acc ? (wr_last ? IDLE : WLOCK) : rd_acc ? (rd_last ? IDLE : RLOCK) : state_q;
        prio_d    = ((wr_acc && wr_last) || (rd_acc && rd_last)) ? !prio_q : prio_q;
        trk_d     = (SLV_WS == 0) ? '0 : TW'({trk_q, rd_acc});
        addr_d    = wr_acc ? wr_addr : rd_acc ? rd_addr : addr_q;
        mem_we    = wr_acc;
        mem_addr  = addr_d;
        mem_be    = wr_acc ? wr_be : '0;
        mem_wdata = wr_data;
        rd_dvalid = (SLV_WS == 0) ? rd_acc : trk_q[TW-1];
        rd_data   = mem_q;
        busy      = (state_q != IDLE) || (|trk_q);
    end
    // state, priority, read-latency tracker and held address
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            trk_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            trk_q   <= trk_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench driving three arbiters (0, 2 and 3 wait states) in lockstep
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_valid = 1'b0, wr_last = 1'b0, rd_valid = 1'b0, rd_last = 1'b0;
    logic [9:0] wr_addr = '0, rd_addr = '0;
    logic [15:0] wr_be = '0;
    logic [127:0] wr_data = '0;
    logic [2:0] w_rdy, r_rdy, r_dv, m_we, bsy;
    logic [2:0][9:0] m_addr;
    logic [2:0][15:0] m_be;
    logic [2:0][127:0] m_wd, m_q, r_data;
    logic [127:0] ref_mem [64];
    int n_vec = 0, n_err = 0, cyc = 0;
    typedef struct {logic [127:0] d; int due;} ent_t;
    ent_t sb[3][$];
    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        logic [127:0] mem [64];
        logic [127:0] pipe [4];
        initial for (int i = 0; i < 64; i++) mem[i] = '0;
        mem_port_arbiter #(.SLV_AW(10), .SLV_BYTES(16), .SLV_WS(W)) dut (
            .usr_clk(clk), .usr_reset(rst),
            .wr_valid(wr_valid), .wr_ready(w_rdy[g]), .wr_addr(wr_addr), .wr_be(wr_be),
            .wr_data(wr_data), .wr_last(wr_last),
            .rd_valid(rd_valid), .rd_ready(r_rdy[g]), .rd_addr(rd_addr), .rd_last(rd_last),
            .rd_dvalid(r_dv[g]), .rd_data(r_data[g]),
            .mem_we(m_we[g]), .mem_addr(m_addr[g]), .mem_be(m_be[g]), .mem_wdata(m_wd[g]),
            .mem_q(m_q[g]), .busy(bsy[g])
        );
        // memory model: byte-enabled writes, reads sampled at the address edge and delayed W cycles
        always @(posedge clk) begin
            if (m_we[g])
                for (int b = 0; b < 16; b++)
                    if (m_be[g][b]) mem[m_addr[g][9:4]][8*b +: 8] <= m_wd[g][8*b +: 8];
            pipe[0] <= mem[m_addr[g][9:4]];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        if (W == 0) begin : z
            assign m_q[g] = mem[m_addr[g][9:4]];
        end else begin : p
            assign m_q[g] = pipe[W-1];
        end
    end

    // scoreboard: push expected read data at accept, pop and compare when due
    always @(negedge clk) begin
        if (rst) begin
            for (int g = 0; g < 3; g++) sb[g].delete();
        end else begin
            if (wr_valid && w_rdy[0])
                for (int b = 0; b < 16; b++)
                    if (wr_be[b]) ref_mem[wr_addr[9:4]][8*b +: 8] = wr_data[8*b +: 8];
            if (rd_valid && r_rdy[0])
                for (int g = 0; g < 3; g++) sb[g].push_back(ent_t'{ref_mem[rd_addr[9:4]], cyc + ws_of(g)});
            for (int g = 0; g < 3; g++) begin
                if (sb[g].size() > 0 && sb[g][0].due <= cyc) begin
                    chk($sformatf("dvalid_ws%0d", ws_of(g)), r_dv[g], 1);
                    chk($sformatf("rdata_ws%0d", ws_of(g)), r_data[g], sb[g][0].d);
                    void'(sb[g].pop_front());
                end else begin
                    chk($sformatf("no_dvalid_ws%0d", ws_of(g)), r_dv[g], 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 0; rd_valid = 0; wr_last = 0; rd_last = 0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] be, input logic [127:0] d, input logic last);
        wr_valid = 1; wr_addr = a; wr_be = be; wr_data = d; wr_last = last;
    endtask

    task automatic rd(input logic [9:0] a, input logic last);
        rd_valid = 1; rd_addr = a; rd_last = last;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("reset_busy", bsy[g], 0);
            chk("reset_we", m_we[g], 0);
            chk("reset_addr", m_addr[g], 0);
            chk("reset_ready", {w_rdy[g], r_rdy[g]}, 0);
        end
        // single write then read-after-write to the same word
        tick(); wr(10'h040, 16'hFFFF, D1, 1);
        @(negedge clk);
        chk("wr_ready_single", w_rdy[0], 1);
        chk("rd_ready_unreq", r_rdy[0], 0);
        chk("mem_we_wr", m_we[0], 1);
        chk("mem_addr_wr", m_addr[0], 10'h040);
        chk("mem_be_wr", m_be[0], 16'hFFFF);
        chk("mem_wdata", m_wd[0], D1);
        tick(); idle(); rd(10'h040, 1);
        @(negedge clk);
        chk("rd_ready_single", r_rdy[0], 1);
        chk("mem_be_rd", m_be[0], 0);
        chk("mem_addr_rd", m_addr[0], 10'h040);
        chk("raw_dvalid", r_dv[0], 1);
        chk("raw_data", r_data[0], D1);
        tick(); idle();
        @(negedge clk);
        chk("addr_hold", m_addr[0], 10'h040);
        chk("we_idle", m_we[0], 0);
        // 4-beat write burst then 4-beat read burst with valid held
        for (int i = 0; i < 4; i++) begin
            tick(); wr(10'(i*16), 16'hFFFF, {4{32'hC0DE0000 + i}}, i == 3);
            @(negedge clk);
            chk("wburst_ready", w_rdy[0], 1);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); idle(); rd(10'(i*16), i == 3);
            @(negedge clk);
            chk("rburst_ready", r_rdy[0], 1);
            chk("rburst_addr", m_addr[0], 10'(i*16));
        end
        tick(); idle();
        repeat (5) tick();
        // both requesters valid from reset, 2-beat bursts each
        rst = 1; tick(); rst = 0;
        wr(10'h100, 16'hFFFF, {4{32'hA5A50001}}, 0); rd(10'h000, 0);
        @(negedge clk);
        chk("both_c0", {w_rdy[0], r_rdy[0]}, 2'b10);
        tick(); wr(10'h110, 16'hFFFF, {4{32'hA5A50002}}, 1);
        @(negedge clk);
        chk("both_c1", {w_rdy[0], r_rdy[0]}, 2'b10);
        tick(); wr(10'h120, 16'hFFFF, {4{32'hA5A50003}}, 1);
        @(negedge clk);
        chk("both_c2", {w_rdy[0], r_rdy[0]}, 2'b01);
        chk("both_c2_we", m_we[0], 0);
        tick(); rd(10'h010, 1);
        @(negedge clk);
        chk("both_c3", {w_rdy[0], r_rdy[0]}, 2'b01);
        tick(); rd(10'h020, 1);
        @(negedge clk);
        chk("both_c4_prio0", {w_rdy[0], r_rdy[0]}, 2'b10);
        tick(); idle();
        repeat (4) tick();
        // write burst with valid gaps: the lock must starve the reader
        wr(10'h200, 16'hFFFF, {4{32'h11112222}}, 0);
        @(negedge clk);
        chk("gap_first", w_rdy[0], 1);
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); rd(10'h200, 1);
            @(negedge clk);
            chk("gap_rd_blocked", r_rdy[0], 0);
            chk("gap_wr_ready", w_rdy[0], 1);
            chk("gap_busy", bsy[0], 1);
            chk("gap_addr_hold", m_addr[0], 10'h200);
        end
        tick(); wr(10'h200, 16'hFFFF, {4{32'h33334444}}, 1);
        @(negedge clk);
        chk("gap_last", {w_rdy[0], r_rdy[0]}, 2'b10);
        tick(); wr_valid = 0; wr_last = 0;
        @(negedge clk);
        chk("gap_rd_after", r_rdy[0], 1);
        tick(); idle();
        repeat (4) tick();
        // single-byte enable over a zero word
        wr(10'h080, 16'hFFFF, '0, 1);
        tick(); wr(10'h080, 16'h0001, {{120{1'b1}}, 8'hAA}, 1);
        tick(); idle(); rd(10'h080, 1);
        @(negedge clk);
        chk("be_dvalid", r_dv[0], 1);
        chk("be_data", r_data[0], 128'hAA);
        tick(); idle();
        repeat (4) tick();
        // reset one cycle after a read accept drops the pending pulses
        rd(10'h040, 1);
        @(negedge clk);
        chk("pre_reset_rd", r_rdy[0], 1);
        tick(); idle(); rst = 1;
        @(negedge clk);
        chk("inflight_busy", bsy[2], 1);
        tick(); rst = 0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("post_reset_busy", bsy[g], 0);
            chk("post_reset_dv", r_dv[g], 0);
        end
        repeat (5) tick();
        // reset mid read burst returns to IDLE with write priority
        rd(10'h000, 0);
        tick(); idle(); rst = 1;
        tick(); rst = 0;
        wr(10'h300, 16'hFFFF, {4{32'h5A5A5A5A}}, 1); rd(10'h000, 1);
        @(negedge clk);
        chk("mid_reset_grant", {w_rdy[0], r_rdy[0]}, 2'b10);
        chk("mid_reset_busy", bsy[0], 0);
        tick(); idle();
        repeat (6) tick();
        for (int g = 0; g < 3; g++) chk("sb_drained", sb[g].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
